// File: rtl/mem_access_stage_pkg.sv
// Shared Y86-64 encodings and memory-stage types for the memory access stage.
// Holds icode/stat encodings, the M pipeline register layout and access-decode helpers.
package mem_access_stage_pkg;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_e;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_e;

    typedef enum logic {
        MST_IDLE = 1'b0,
        MST_REQ  = 1'b1
    } mst_e;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } m_reg_t;

    localparam m_reg_t M_BUBBLE = '{
        icode: INOP,
        stat:  SAOK,
        cnd:   1'b0,
        val_e: 64'd0,
        val_a: 64'd0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    function automatic logic is_read_icode(input logic [3:0] icode);
        return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
    endfunction

    function automatic logic is_write_icode(input logic [3:0] icode);
        return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
    endfunction

    // Pops and returns read from the old stack pointer, which travels in valA.
    function automatic logic uses_val_a_addr(input logic [3:0] icode);
        return (icode == IPOPQ) || (icode == IRET);
    endfunction

endpackage

// File: rtl/mem_access_stage.sv
// Y86-64 memory stage: M pipeline register plus a req/ack data-memory handshake
// with address legality check, access timeout and upstream stall indication.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  e_icode_i,
    input  logic [2:0]  e_stat_i,
    input  logic [63:0] e_valE_i,
    input  logic [63:0] e_valA_i,
    input  logic [3:0]  e_dstE_i,
    input  logic [3:0]  e_dstM_i,
    input  logic        e_Cnd_i,
    input  logic        M_stall_i,
    input  logic        M_bubble_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic        dmem_err_i,
    input  logic [63:0] dmem_rdata_i,
    output logic [3:0]  M_icode_o,
    output logic        M_Cnd_o,
    output logic [63:0] M_valE_o,
    output logic [63:0] M_valA_o,
    output logic [3:0]  M_dstE_o,
    output logic [3:0]  M_dstM_o,
    output logic [63:0] m_valM_o,
    output logic [2:0]  m_stat_o,
    output logic        mem_busy_o
);

    localparam int              CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [63:0]     ADDR_MAX  = 64'(MEM_BYTES - 8);

    mst_e             state_q, state_d;
    m_reg_t           m_q;
    logic [63:0]      val_m_q;
    logic             req_q;
    logic             we_q;
    logic [63:0]      addr_q;
    logic [63:0]      wdata_q;
    logic [CNT_W-1:0] tmo_cnt_q;

    logic             e_is_read;
    logic             e_is_write;
    logic             e_access;
    logic [63:0]      e_addr;
    logic             e_legal;
    logic [2:0]       e_stat_next;

    logic             load_en;
    logic             bubble_en;
    logic             start_req;
    logic             ack_done;
    logic             timed_out;

    assign e_is_read   = is_read_icode(e_icode_i);
    assign e_is_write  = is_write_icode(e_icode_i);
    assign e_access    = e_is_read || e_is_write;
    assign e_addr      = uses_val_a_addr(e_icode_i) ? e_valA_i : e_valE_i;
    assign e_legal     = (e_addr <= ADDR_MAX);

    // An upstream fault wins over a local address fault and suppresses the access.
    assign e_stat_next = (e_stat_i != SAOK)         ? e_stat_i :
                         (e_access && !e_legal)     ? SADR     : SAOK;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        load_en   = 1'b0;
        bubble_en = 1'b0;
        start_req = 1'b0;
        ack_done  = 1'b0;
        timed_out = 1'b0;
        unique case (state_q)
            MST_IDLE: begin
                bubble_en = !M_stall_i && M_bubble_i;
                load_en   = !M_stall_i && !M_bubble_i;
                if (load_en && e_access && e_legal && (e_stat_i == SAOK)) begin
                    start_req = 1'b1;
                    state_d   = MST_REQ;
                end
            end
            MST_REQ: begin
                if (dmem_ack_i) begin
                    ack_done = 1'b1;
                    state_d  = MST_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timed_out = 1'b1;
                    state_d   = MST_IDLE;
                end
            end
            default: state_d = MST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= MST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            m_q       <= M_BUBBLE;
            val_m_q   <= 64'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            tmo_cnt_q <= '0;
        end else begin
            if (bubble_en) begin
                m_q <= M_BUBBLE;
            end else if (load_en) begin
                m_q.icode <= e_icode_i;
                m_q.stat  <= e_stat_next;
                m_q.cnd   <= e_Cnd_i;
                m_q.val_e <= e_valE_i;
                m_q.val_a <= e_valA_i;
                m_q.dst_e <= e_dstE_i;
                m_q.dst_m <= e_dstM_i;
            end

            if (start_req) begin
                req_q     <= 1'b1;
                we_q      <= e_is_write;
                addr_q    <= e_addr;
                wdata_q   <= e_valA_i;
                tmo_cnt_q <= '0;
            end else if (ack_done) begin
                req_q <= 1'b0;
                if (!we_q) begin
                    val_m_q <= dmem_rdata_i;
                end
                if (dmem_err_i) begin
                    m_q.stat <= SADR;
                end
            end else if (timed_out) begin
                req_q    <= 1'b0;
                m_q.stat <= SADR;
            end else if (state_q == MST_REQ) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;

    assign M_icode_o    = m_q.icode;
    assign M_Cnd_o      = m_q.cnd;
    assign M_valE_o     = m_q.val_e;
    assign M_valA_o     = m_q.val_a;
    assign M_dstE_o     = m_q.dst_e;
    assign M_dstM_o     = m_q.dst_m;

    assign m_valM_o     = val_m_q;
    assign m_stat_o     = m_q.stat;
    assign mem_busy_o   = (state_q == MST_REQ);

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: reset, reads, writes,
// address faults, error ack, timeout and M-register control.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int MEM_BYTES = 8192;
    localparam int TIMEOUT   = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [3:0]  e_icode_i;
    logic [2:0]  e_stat_i;
    logic [63:0] e_valE_i;
    logic [63:0] e_valA_i;
    logic [3:0]  e_dstE_i;
    logic [3:0]  e_dstM_i;
    logic        e_Cnd_i;
    logic        M_stall_i;
    logic        M_bubble_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [63:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic        dmem_err_i;
    logic [63:0] dmem_rdata_i;
    logic [3:0]  M_icode_o;
    logic        M_Cnd_o;
    logic [63:0] M_valE_o;
    logic [63:0] M_valA_o;
    logic [3:0]  M_dstE_o;
    logic [3:0]  M_dstM_o;
    logic [63:0] m_valM_o;
    logic [2:0]  m_stat_o;
    logic        mem_busy_o;

    int errors = 0;
    int checks = 0;
    int busy_n;

    mem_access_stage #(
        .MEM_BYTES (MEM_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .e_icode_i    (e_icode_i),
        .e_stat_i     (e_stat_i),
        .e_valE_i     (e_valE_i),
        .e_valA_i     (e_valA_i),
        .e_dstE_i     (e_dstE_i),
        .e_dstM_i     (e_dstM_i),
        .e_Cnd_i      (e_Cnd_i),
        .M_stall_i    (M_stall_i),
        .M_bubble_i   (M_bubble_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_err_i   (dmem_err_i),
        .dmem_rdata_i (dmem_rdata_i),
        .M_icode_o    (M_icode_o),
        .M_Cnd_o      (M_Cnd_o),
        .M_valE_o     (M_valE_o),
        .M_valA_o     (M_valA_o),
        .M_dstE_o     (M_dstE_o),
        .M_dstM_o     (M_dstM_o),
        .m_valM_o     (m_valM_o),
        .m_stat_o     (m_stat_o),
        .mem_busy_o   (mem_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_e(input logic [3:0] icode, input logic [2:0] stat,
                           input logic [63:0] val_e, input logic [63:0] val_a,
                           input logic [3:0] dst_e, input logic [3:0] dst_m,
                           input logic cnd);
        e_icode_i = icode;
        e_stat_i  = stat;
        e_valE_i  = val_e;
        e_valA_i  = val_a;
        e_dstE_i  = dst_e;
        e_dstM_i  = dst_m;
        e_Cnd_i   = cnd;
    endtask

    task automatic idle_e();
        drive_e(INOP, SAOK, 64'd0, 64'd0, RNONE, RNONE, 1'b0);
    endtask

    // Counts busy cycles, raising ack in busy cycle number ack_at (0 = never).
    task automatic run_access(input int ack_at, input logic err, input logic [63:0] rdata,
                              output int n);
        n = 0;
        while (mem_busy_o && n < 40) begin
            n++;
            if (n == ack_at) begin
                dmem_ack_i   = 1'b1;
                dmem_err_i   = err;
                dmem_rdata_i = rdata;
            end
            step();
            dmem_ack_i = 1'b0;
            dmem_err_i = 1'b0;
        end
    endtask

    initial begin
        rst_n_i      = 1'b0;
        M_stall_i    = 1'b0;
        M_bubble_i   = 1'b0;
        dmem_ack_i   = 1'b0;
        dmem_err_i   = 1'b0;
        dmem_rdata_i = 64'd0;
        idle_e();

        step();
        step();
        check("rst_icode", 64'(M_icode_o), 64'(INOP));
        check("rst_dstE",  64'(M_dstE_o),  64'hF);
        check("rst_req",   64'(dmem_req_o), 64'd0);
        check("rst_busy",  64'(mem_busy_o), 64'd0);
        check("rst_stat",  64'(m_stat_o),  64'(SAOK));
        check("rst_valM",  m_valM_o,       64'd0);
        rst_n_i = 1'b1;

        // Read with ack in the third request cycle.
        drive_e(IMRMOVQ, SAOK, 64'h100, 64'd0, RNONE, 4'h3, 1'b0);
        step();
        idle_e();
        check("rd_req",  64'(dmem_req_o), 64'd1);
        check("rd_we",   64'(dmem_we_o),  64'd0);
        check("rd_addr", dmem_addr_o,     64'h100);
        run_access(3, 1'b0, 64'hDEAD, busy_n);
        check("rd_busy_n", 64'(busy_n),     64'd3);
        check("rd_valM",   m_valM_o,        64'hDEAD);
        check("rd_stat",   64'(m_stat_o),   64'(SAOK));
        check("rd_req_lo", 64'(dmem_req_o), 64'd0);
        check("rd_icode",  64'(M_icode_o),  64'(IMRMOVQ));

        // Write with same-cycle ack.
        drive_e(IPUSHQ, SAOK, 64'h1F8, 64'h55, 4'h4, RNONE, 1'b0);
        step();
        idle_e();
        check("wr_req",   64'(dmem_req_o), 64'd1);
        check("wr_we",    64'(dmem_we_o),  64'd1);
        check("wr_addr",  dmem_addr_o,     64'h1F8);
        check("wr_wdata", dmem_wdata_o,    64'h55);
        run_access(1, 1'b0, 64'h0, busy_n);
        check("wr_busy_n", 64'(busy_n),   64'd1);
        check("wr_stat",   64'(m_stat_o), 64'(SAOK));
        check("wr_valM",   m_valM_o,      64'hDEAD);

        // Address legality boundary.
        drive_e(IRMMOVQ, SAOK, 64'(MEM_BYTES - 7), 64'h9, RNONE, RNONE, 1'b0);
        step();
        idle_e();
        check("adr_over_req",  64'(dmem_req_o), 64'd0);
        check("adr_over_busy", 64'(mem_busy_o), 64'd0);
        check("adr_over_stat", 64'(m_stat_o),   64'(SADR));

        drive_e(IRMMOVQ, SAOK, 64'(MEM_BYTES - 8), 64'h9, RNONE, RNONE, 1'b0);
        step();
        idle_e();
        check("adr_edge_req",  64'(dmem_req_o), 64'd1);
        check("adr_edge_addr", dmem_addr_o,     64'(MEM_BYTES - 8));
        run_access(1, 1'b0, 64'h0, busy_n);
        check("adr_edge_stat", 64'(m_stat_o), 64'(SAOK));

        drive_e(IMRMOVQ, SAOK, 64'h1_0000_0100, 64'd0, RNONE, 4'h3, 1'b0);
        step();
        idle_e();
        check("adr_high_req",  64'(dmem_req_o), 64'd0);
        check("adr_high_stat", 64'(m_stat_o),   64'(SADR));

        // Error ack on a read.
        drive_e(IMRMOVQ, SAOK, 64'h200, 64'd0, RNONE, 4'h3, 1'b0);
        step();
        idle_e();
        run_access(2, 1'b1, 64'h1234, busy_n);
        check("err_busy_n", 64'(busy_n),   64'd2);
        check("err_stat",   64'(m_stat_o), 64'(SADR));

        // A following non-memory instruction clears the status.
        step();
        check("nop_stat", 64'(m_stat_o), 64'(SAOK));

        // Timeout.
        drive_e(IMRMOVQ, SAOK, 64'h300, 64'd0, RNONE, 4'h3, 1'b0);
        step();
        idle_e();
        run_access(0, 1'b0, 64'h0, busy_n);
        check("tmo_busy_n", 64'(busy_n),     64'(TIMEOUT));
        check("tmo_req",    64'(dmem_req_o), 64'd0);
        check("tmo_busy",   64'(mem_busy_o), 64'd0);
        check("tmo_stat",   64'(m_stat_o),   64'(SADR));

        // Upstream fault suppresses the access.
        drive_e(IMRMOVQ, SINS, 64'h100, 64'd0, RNONE, 4'h3, 1'b0);
        step();
        idle_e();
        check("sins_req",  64'(dmem_req_o), 64'd0);
        check("sins_stat", 64'(m_stat_o),   64'(SINS));

        // Pop addresses memory with valA.
        drive_e(IPOPQ, SAOK, 64'h48, 64'h40, 4'h4, 4'h5, 1'b0);
        step();
        idle_e();
        check("pop_addr", dmem_addr_o, 64'h40);
        run_access(1, 1'b0, 64'h77, busy_n);
        check("pop_valM", m_valM_o, 64'h77);

        // Non-memory op: zero added cycles.
        drive_e(IOPQ, SAOK, 64'hAA, 64'h1, 4'h2, RNONE, 1'b1);
        step();
        check("op_busy",  64'(mem_busy_o), 64'd0);
        check("op_icode", 64'(M_icode_o),  64'(IOPQ));
        check("op_cnd",   64'(M_Cnd_o),    64'd1);
        check("op_valE",  M_valE_o,        64'hAA);
        check("op_dstE",  64'(M_dstE_o),   64'h2);

        // Stall has priority over bubble.
        drive_e(IMRMOVQ, SAOK, 64'h100, 64'd0, RNONE, 4'h3, 1'b0);
        M_stall_i  = 1'b1;
        M_bubble_i = 1'b1;
        step();
        check("stall_icode", 64'(M_icode_o),  64'(IOPQ));
        check("stall_valE",  M_valE_o,        64'hAA);
        check("stall_req",   64'(dmem_req_o), 64'd0);

        M_stall_i = 1'b0;
        step();
        check("bub_icode", 64'(M_icode_o), 64'(INOP));
        check("bub_dstE",  64'(M_dstE_o),  64'hF);
        check("bub_cnd",   64'(M_Cnd_o),   64'd0);
        M_bubble_i = 1'b0;
        idle_e();

        // Reset during an access discards the ack.
        drive_e(IMRMOVQ, SAOK, 64'h180, 64'd0, RNONE, 4'h3, 1'b0);
        step();
        idle_e();
        check("rr_busy", 64'(mem_busy_o), 64'd1);
        rst_n_i      = 1'b0;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 64'hBEEF;
        step();
        dmem_ack_i = 1'b0;
        check("rr_req",   64'(dmem_req_o), 64'd0);
        check("rr_busy0", 64'(mem_busy_o), 64'd0);
        check("rr_valM",  m_valM_o,        64'd0);
        check("rr_icode", 64'(M_icode_o),  64'(INOP));
        rst_n_i = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
